// File: rtl/restoring_div_24b.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH cycles per division.
// Optional two's-complement mode is enabled by defining DIV_SIGNED_EN.
module restoring_div_24b #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff_lo;
  logic               ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               last_step;
  logic               accept;
  logic               dvs_zero;

`ifdef DIV_SIGNED_EN
  logic qneg_q;
  logic rneg_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? WIDTH'(-x) : x;
  endfunction
`endif

  assign accept    = (state == IDLE) && start;
  assign dvs_zero  = (divisor == '0);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // One restoring step: the partial remainder is always below the divisor, so the
  // shifted value fits WIDTH+1 bits and the kept result fits WIDTH bits.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dvs_q});
  assign diff_lo  = WIDTH'(shifted - {1'b0, dvs_q});
  assign rem_step = ge ? diff_lo : shifted[WIDTH-1:0];
  assign quo_step = {dvd_q[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dvs_zero ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else if (accept) begin
      rem_q <= '0;
      cnt_q <= '0;
`ifdef DIV_SIGNED_EN
      dvd_q  <= mag(dividend);
      dvs_q  <= mag(divisor);
      qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_q <= dividend[WIDTH-1];
`else
      dvd_q <= dividend;
      dvs_q <= divisor;
`endif
      // Zero divisor bypasses the iteration and publishes its result directly.
      if (dvs_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd_q <= quo_step;
      rem_q <= rem_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
`ifdef DIV_SIGNED_EN
        quotient  <= apply_sign(quo_step, qneg_q);
        remainder <= apply_sign(rem_step, rneg_q);
`else
        quotient  <= quo_step;
        remainder <= rem_step;
`endif
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_div_24b.sv
// Scoreboard bench for restoring_div_24b: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_restoring_div_24b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        busy;
  logic        done;
  logic [23:0] quotient;
  logic [23:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [23:0] q;
    logic [23:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  int   n_push   = 0;

  always #5 clk = ~clk;

  restoring_div_24b #(.WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [23:0] q, input logic [23:0] r, input logic z);
    exp_t e;
    e.q = q; e.r = r; e.z = z;
    sb.push_back(e);
    n_push++;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
      end
    end
  end

  // Start one operation after a posedge; optionally re-pulse start mid-run.
  task automatic run_op(input logic [23:0] dd, input logic [23:0] dv,
                        input logic [23:0] eq, input logic [23:0] er, input logic ez,
                        input int lat, input int repulse_at);
    int n;
    expect_result(eq, er, ez);
    @(posedge clk); #1;
    start = 1'b1; dividend = dd; divisor = dv;
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
      end
      if (repulse_at != 0 && n == repulse_at) begin
        start = 1'b1; dividend = 24'd50; divisor = 24'd5;
      end
      if (repulse_at != 0 && n == repulse_at + 1) start = 1'b0;
      if (done) break;
    end
    chk("latency", n, lat);
    @(posedge clk); #1;
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    int n;
    int t1;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", busy, 0);

    run_op(24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 25, 0);
    run_op(24'h123456, 24'd0, 24'hFFFFFF, 24'h123456, 1'b1, 1, 0);
    run_op(24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 1'b0, 25, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_quotient", quotient, 24'hFFFFFF);
    chk("hold_remainder", remainder, 24'd0);
    run_op(24'd5, 24'd9, 24'd0, 24'd5, 1'b0, 25, 0);
    run_op(24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 25, 10);
`ifdef DIV_SIGNED_EN
    run_op(24'hFFFF9C, 24'd7, 24'hFFFFF2, 24'hFFFFFE, 1'b0, 25, 0);
    run_op(24'h800000, 24'hFFFFFF, 24'h800000, 24'd0, 1'b0, 25, 0);
`else
    run_op(24'hABCDEF, 24'h001000, 24'h000ABC, 24'h000DEF, 1'b0, 25, 0);
`endif

    // Abort a running division with reset at edge 12.
    @(posedge clk); #1;
    start = 1'b1; dividend = 24'd100; divisor = 24'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", busy, 0);
    run_op(24'd81, 24'd9, 24'd9, 24'd0, 1'b0, 25, 0);

    // Back-to-back with start held high.
    expect_result(24'd30, 24'd10, 1'b0);
    expect_result(24'd3, 24'd1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; dividend = 24'd1000; divisor = 24'd33;
    n = 0; t1 = 0;
    while (n < 200) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin dividend = 24'd7; divisor = 24'd2; end
      if (done && t1 == 0) t1 = n;
      else if (done) break;
    end
    start = 1'b0;
    chk("b2b_first_latency", t1, 25);
    chk("b2b_period", n - t1, 26);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", done_cnt, n_push);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
